// File: rtl/key_debounce_if.sv
// Key pin bundle: raw pins in, debounced level and one-cycle press/release pulses out.
// master drives the raw pins; slave is the debouncer that conditions them.
interface key_debounce_if #(
  parameter int KEY_WIDTH = 4
);
  logic [KEY_WIDTH-1:0] key_in;
  logic [KEY_WIDTH-1:0] key_state;
  logic [KEY_WIDTH-1:0] key_press;
  logic [KEY_WIDTH-1:0] key_release;

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-flop synchroniser plus stability counter; level accepted after DEBOUNCE_CYCLES stable cycles.
// Latency DEBOUNCE_CYCLES+2 edges inclusive of the sampling edge; free-running, no backpressure.
module key_debounce #(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic          clk,
  input  logic          reset,
  key_debounce_if.slave keys
);

  localparam int                   CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic                 IDLE_BIT = (ACTIVE_LOW != 0);
  localparam logic [KEY_WIDTH-1:0] IDLE     = {KEY_WIDTH{IDLE_BIT}};

  logic [KEY_WIDTH-1:0] sync_d1;
  logic [KEY_WIDTH-1:0] sync_q;
  logic [KEY_WIDTH-1:0] state_q;
  logic [KEY_WIDTH-1:0] state_d;
  logic [KEY_WIDTH-1:0] press_q;
  logic [KEY_WIDTH-1:0] press_d;
  logic [KEY_WIDTH-1:0] release_q;
  logic [KEY_WIDTH-1:0] release_d;
  logic [CNT_W-1:0]     cnt_q [KEY_WIDTH];
  logic [CNT_W-1:0]     cnt_d [KEY_WIDTH];

  // Sync chain resets to the idle level so release from reset never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d1 <= IDLE;
      sync_q  <= IDLE;
    end else begin
      sync_d1 <= keys.key_in;
      sync_q  <= sync_d1;
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = '0;
    release_d = '0;
    for (int k = 0; k < KEY_WIDTH; k++) begin
      cnt_d[k] = '0;
      if (sync_q[k] != state_q[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          state_d[k] = sync_q[k];
          if (sync_q[k] == IDLE_BIT) begin
            release_d[k] = 1'b1;
          end else begin
            press_d[k] = 1'b1;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < KEY_WIDTH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < KEY_WIDTH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign keys.key_state   = state_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed scenarios plus random key activity, checked against a sliding-window model of the acceptance rule.
module tb_key_debounce;
  localparam int KW = 4;
  localparam int D  = 8;
  localparam int AL = 1;
  localparam logic [KW-1:0] IDLE = 4'b1111;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rst_req = 1'b0;
  always #5 clk = ~clk;

  key_debounce_if #(.KEY_WIDTH(KW)) kif ();

  key_debounce #(
    .KEY_WIDTH(KW),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .keys(kif)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: sync is a two-sample delay; a key takes the synced level once the last D
  // synced samples since its previous acceptance (or reset) all differ from its current level.
  logic [KW-1:0] m_s1, m_s2, m_state, m_press, m_rel;
  logic [KW-1:0] hist[$];
  int n;
  int last_ev[KW];

  task automatic model_reset();
    m_s1 = IDLE; m_s2 = IDLE; m_state = IDLE; m_press = '0; m_rel = '0;
    hist.delete();
    n = 0;
    for (int k = 0; k < KW; k++) last_ev[k] = 0;
  endtask

  task automatic model_step(input logic [KW-1:0] kin);
    logic [KW-1:0] sync_now;
    logic [KW-1:0] h;
    bit stable;
    sync_now = m_s2;
    m_s2 = m_s1;
    m_s1 = kin;
    n++;
    hist.push_back(sync_now);
    if (hist.size() > D) void'(hist.pop_front());
    m_press = '0;
    m_rel = '0;
    for (int k = 0; k < KW; k++) begin
      if (n - last_ev[k] >= D) begin
        stable = 1'b1;
        for (int j = 0; j < D; j++) begin
          h = hist[j];
          if (h[k] == m_state[k]) stable = 1'b0;
        end
        if (stable) begin
          m_state[k] = sync_now[k];
          if (sync_now[k] == IDLE[k]) m_rel[k] = 1'b1;
          else m_press[k] = 1'b1;
          last_ev[k] = n;
        end
      end
    end
  endtask

  logic [KW-1:0] prev_state = IDLE;
  bit changed;
  int press_cnt[KW];
  int rel_cnt[KW];

  task automatic clear_counts();
    for (int k = 0; k < KW; k++) begin
      press_cnt[k] = 0;
      rel_cnt[k] = 0;
    end
  endtask

  task automatic tick(input logic [KW-1:0] kin);
    @(negedge clk);
    reset = rst_req;
    kif.key_in = kin;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(kin);
    cyc++;
    #1;
    check_eq("key_state", 32'(kif.key_state), 32'(m_state));
    check_eq("key_press", 32'(kif.key_press), 32'(m_press));
    check_eq("key_release", 32'(kif.key_release), 32'(m_rel));
    changed = (kif.key_state != prev_state);
    prev_state = kif.key_state;
    for (int k = 0; k < KW; k++) begin
      press_cnt[k] += int'(kif.key_press[k]);
      rel_cnt[k] += int'(kif.key_release[k]);
    end
  endtask

  // Asserts reset between edges and checks that it acts before the next edge.
  task automatic apply_reset(input int hold, input logic [KW-1:0] kin);
    #2;
    reset = 1'b1;
    rst_req = 1'b1;
    #1;
    model_reset();
    check_eq("rst_state", 32'(kif.key_state), 32'(IDLE));
    check_eq("rst_press", 32'(kif.key_press), 32'd0);
    check_eq("rst_release", 32'(kif.key_release), 32'd0);
    prev_state = kif.key_state;
    repeat (hold) tick(kin);
    rst_req = 1'b0;
  endtask

  // Ticks until key_state changes; latency counts the sampling edge as edge 1.
  task automatic run_until_change(input logic [KW-1:0] kin, input int sample_cyc, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick(kin);
      if (changed) seen = 1'b1;
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) check_eq({tag, "_latency"}, 32'(cyc - sample_cyc + 1), 32'(D + 2));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int hold_left[KW];
    logic [KW-1:0] cur;
    logic b;

    kif.key_in = 4'b0000;
    model_reset();

    // 1: reset with keys pressed, state held idle afterwards
    clear_counts();
    apply_reset(3, 4'b0000);
    repeat (7) tick(4'b0000);
    check_eq("s1_hold_state", 32'(kif.key_state), 32'(IDLE));
    check_eq("s1_no_press", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
    repeat (20) tick(4'b1111);

    // 2: clean press of key 0
    clear_counts();
    tick(4'b1110);
    s = cyc;
    run_until_change(4'b1110, s, "s2_press");
    check_eq("s2_state", 32'(kif.key_state), 32'(4'b1110));
    check_eq("s2_pulse", 32'(kif.key_press), 32'(4'b0001));
    repeat (12) tick(4'b1110);
    check_eq("s2_press_cnt", 32'(press_cnt[0]), 32'd1);
    check_eq("s2_rel_cnt", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd0);

    // 3: key 1 bounces every 3 cycles, then settles low
    clear_counts();
    for (int i = 0; i < 40; i++) begin
      b = ((i / 3) % 2) != 0;
      tick({2'b11, b, 1'b0});
    end
    check_eq("s3_bounce_state", 32'(kif.key_state), 32'(4'b1110));
    check_eq("s3_bounce_press", 32'(press_cnt[1]), 32'd0);
    tick(4'b1100);
    s = cyc;
    run_until_change(4'b1100, s, "s3_settle");
    check_eq("s3_pulse", 32'(kif.key_press), 32'(4'b0010));
    repeat (12) tick(4'b1100);
    check_eq("s3_press_cnt", 32'(press_cnt[1]), 32'd1);

    // 4: 7-cycle glitch on key 2 rejected, 8-cycle low accepted then released
    clear_counts();
    repeat (7) tick(4'b1000);
    repeat (20) tick(4'b1100);
    check_eq("s4_glitch_state", 32'(kif.key_state), 32'(4'b1100));
    check_eq("s4_glitch_press", 32'(press_cnt[2]), 32'd0);
    tick(4'b1000);
    s = cyc;
    repeat (7) tick(4'b1000);
    run_until_change(4'b1100, s, "s4_press");
    check_eq("s4_press_state", 32'(kif.key_state), 32'(4'b1000));
    run_until_change(4'b1100, s + 8, "s4_release");
    check_eq("s4_rel_pulse", 32'(kif.key_release), 32'(4'b0100));
    repeat (12) tick(4'b1100);
    check_eq("s4_rel_cnt", 32'(rel_cnt[2]), 32'd1);
    check_eq("s4_press_cnt", 32'(press_cnt[2]), 32'd1);

    // 5: all keys pressed on the same cycle
    repeat (20) tick(4'b1111);
    clear_counts();
    tick(4'b0000);
    s = cyc;
    run_until_change(4'b0000, s, "s5_all");
    check_eq("s5_state", 32'(kif.key_state), 32'(4'b0000));
    check_eq("s5_pulse", 32'(kif.key_press), 32'(4'b1111));
    repeat (20) tick(4'b1111);

    // 6: reset in the middle of a count on key 3
    clear_counts();
    repeat (6) tick(4'b0111);
    apply_reset(2, 4'b0111);
    tick(4'b0111);
    s = cyc;
    run_until_change(4'b0111, s, "s6_after_rst");
    check_eq("s6_state", 32'(kif.key_state), 32'(4'b0111));
    repeat (12) tick(4'b0111);
    check_eq("s6_press_cnt", 32'(press_cnt[3]), 32'd1);

    // Random phase: independent per-key hold times around the debounce threshold
    cur = kif.key_in;
    for (int k = 0; k < KW; k++) hold_left[k] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < KW; k++) begin
        hold_left[k]--;
        if (hold_left[k] <= 0) begin
          cur[k] = ~cur[k];
          hold_left[k] = int'($urandom_range(1, 14));
        end
      end
      if ($urandom_range(0, 499) == 0) apply_reset(int'($urandom_range(1, 3)), cur);
      else tick(cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
